dnn_ami_write_sequencer: RTL and testbench
==========================================

# dnn_ami_write_sequencer

Write-path bridge between DNNWeaver processing units (PUs) and the AMI memory request interface. The block queues macro write requests (address, size, PU id), breaks each into 8-byte AMI write requests, and pulls data from the selected PU's output buffer. Requests are buffered in an outbound queue that feeds the memory system through a valid/grant handshake. It sits between the DNNWeaver memory controller and the AMI request arbiter.

## Interface

Parameters:
- NUM_PU, 2, number of PUs / output buffers
- AXI_ADDR_WIDTH, 32, macro request address width
- AXI_DATA_WIDTH, 64, data width per PU (one 8-byte beat)
- TX_SIZE_WIDTH, 10, macro request size field width (count of 8-byte beats)
- NUM_PU_W, clog2(NUM_PU)+1, PU id width
- MACRO_Q_LOG_DEPTH, 3, log2 depth of macro request queue
- REQ_Q_LOG_DEPTH, 3, log2 depth of AMI request queue
- USE_SOFT_FIFO, 0, selects the FIFO implementation style; behaviour is identical for both settings

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reqValid  out  1  AMI request at queue head is valid
- reqOut_grant  in  1  memory system accepts reqOut this cycle
- reqOut  out  AMI_REQ_W  head of AMI request queue
- outbuf_empty  in  NUM_PU  per-PU output buffer empty
- data_from_outbuf  in  NUM_PU*AXI_DATA_WIDTH  PU p data in bits [(p+1)*64-1 : p*64]
- write_valid  in  NUM_PU  ignored, reserved
- outbuf_pop  out  NUM_PU  combinational one-hot dequeue strobe to PU buffer
- wr_req  in  1  macro write request strobe
- wr_pu_id  in  NUM_PU_W  source PU
- wr_req_size  in  TX_SIZE_WIDTH  number of 8-byte beats
- wr_addr  in  AXI_ADDR_WIDTH  start byte address
- wr_ready  out  1  block fully idle
- wr_done  out  1  one-cycle pulse when a macro request finishes sequencing

## Operation

- AMI request fields, LSB first: size[7:0], data[AXI_DATA_WIDTH], addr[63:0], isWrite, valid.
- Macro entry fields: valid, isWrite=1, addr, size, pu_id, 64-bit timestamp (captured, not consumed).
- Timestamp: free-running 64-bit counter; 0 in the cycle after reset, +1 every cycle, wraps.
- Enqueue: macro entry written when wr_req && !macro_full. A request arriving while full is dropped; callers gate on wr_ready.
- Sequencer states: IDLE, ACTIVE. Registers: cur_addr, left, pu_id.
- IDLE: if macro queue is non-empty, dequeue the head (show-ahead), load cur_addr=addr, left=size, pu_id, and go to ACTIVE.
- ACTIVE, issue condition !outbuf_empty[pu_id] && !req_full: assert outbuf_pop[pu_id]; enqueue {valid=1, isWrite=1, addr=zero-extended cur_addr, data=PU slice, size=8}; cur_addr+=8 (wraps at AXI_ADDR_WIDTH); left-=1. If left was 1, go to IDLE and set done.
- ACTIVE with left==0 (size-0 request): go to IDLE and set done; no beat issued.
- wr_done is the done flag registered, so it pulses for one cycle, the cycle after the last issue.
- Output: reqValid = !req_empty && head.valid; reqOut = head; dequeue when reqOut_grant && reqValid.
- wr_ready = macro_empty && IDLE && req_empty (combinational).

## Timing

- Reset values: IDLE, counters 0, both queues empty. Outputs: reqValid=0, wr_done=0, outbuf_pop=0, wr_ready=1.
- Queue write data is visible at the head on the cycle after the enqueue.
- wr_req in cycle 0 → macro non-empty in cycle 1 → ACTIVE in cycle 2 → first pop in cycle 2 if data is present → reqValid in cycle 3.
- Maximum throughput is one beat per cycle.
- Back-pressure: a full request queue or an empty outbuf stalls issue with no pop and no loss of state.
- Simultaneous enqueue and dequeue on a full queue: dequeue takes effect; the enqueue is blocked by the full flag.
- The sequencer never dequeues the macro queue and issues a beat in the same cycle.
- Reset mid-operation drops all queued and in-flight state.

## Structure

- Shared package/header contains the AMI request field offsets and width, the DNNWeaver memreq field offsets and width, and the queue depth constants.
- Sub-module sync_fifo(WIDTH, LOG_DEPTH) is instantiated twice. It is a show-ahead FIFO with full/empty flags and synchronous reset.
- The timestamp counter is a trivial inline register.

## Test plan

- After reset: wr_ready=1, reqValid=0, wr_done=0, outbuf_pop=0.
- wr_addr=0x1000, size=3, pu_id=1, outbuf 1 non-empty with data 0xA.., reqOut_grant=1 → three requests at addresses 0x1000, 0x1008, 0x1010 carrying PU1 data, size=8, isWrite=1; outbuf_pop=2'b10 for 3 cycles; a single wr_done pulse; wr_ready=1 afterwards.
- Same request with outbuf_empty toggling every cycle → pops only on non-empty cycles; exactly 3 requests issued.
- reqOut_grant=0 with a request of 2^REQ_Q_LOG_DEPTH+2 beats → the request queue fills; pops stop at full; issue resumes when grant is asserted; no beats lost and addresses stay in order.
- size=0 request → no pop, no reqValid, one wr_done pulse.
- Two back-to-back wr_req (0x0 size 2 on PU0, 0x100 size 1 on PU1) → requests at 0x0, 0x8, then 0x100; two wr_done pulses; rst asserted mid-sequence → immediate return to reset values.

Source files
------------

// File: rtl/dnn_ami_write_sequencer_pkg.sv
// Shared field layout and depth constants for the DNNWeaver -> AMI write path.
package dnn_ami_write_sequencer_pkg;

   // Default queue depths (log2)
   localparam int MACRO_Q_LOG_DEPTH_DEF = 3;
   localparam int REQ_Q_LOG_DEPTH_DEF   = 3;

   // AMI request layout, LSB first: size, data, addr, isWrite, valid
   localparam int         AMI_SIZE_LSB   = 0;
   localparam int         AMI_SIZE_W     = 8;
   localparam int         AMI_DATA_LSB   = AMI_SIZE_LSB + AMI_SIZE_W;
   localparam int         AMI_ADDR_W     = 64;
   localparam logic [7:0] AMI_BEAT_BYTES = 8'd8;

   function automatic int ami_addr_lsb(input int dw);
      return AMI_DATA_LSB + dw;
   endfunction

   function automatic int ami_is_write_bit(input int dw);
      return ami_addr_lsb(dw) + AMI_ADDR_W;
   endfunction

   function automatic int ami_valid_bit(input int dw);
      return ami_is_write_bit(dw) + 1;
   endfunction

   function automatic int ami_req_width(input int dw);
      return ami_valid_bit(dw) + 1;
   endfunction

   // DNNWeaver memreq layout, LSB first: timestamp, pu_id, size, addr, isWrite, valid
   localparam int MEM_TS_LSB = 0;
   localparam int MEM_TS_W   = 64;
   localparam int MEM_PU_LSB = MEM_TS_LSB + MEM_TS_W;

   function automatic int mem_size_lsb(input int pw);
      return MEM_PU_LSB + pw;
   endfunction

   function automatic int mem_addr_lsb(input int pw, input int sw);
      return mem_size_lsb(pw) + sw;
   endfunction

   function automatic int mem_is_write_bit(input int pw, input int sw, input int aw);
      return mem_addr_lsb(pw, sw) + aw;
   endfunction

   function automatic int mem_valid_bit(input int pw, input int sw, input int aw);
      return mem_is_write_bit(pw, sw, aw) + 1;
   endfunction

   function automatic int mem_req_width(input int pw, input int sw, input int aw);
      return mem_valid_bit(pw, sw, aw) + 1;
   endfunction

   typedef enum logic {
      SEQ_IDLE   = 1'b0,
      SEQ_ACTIVE = 1'b1
   } seq_state_t;

endpackage

// File: rtl/dnn_ami_write_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is readable without a read strobe.
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int LOG_DEPTH = 3,
   parameter bit USE_SOFT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr_reg;
   logic [LOG_DEPTH:0] rd_ptr_reg;
   logic               do_wr;
   logic               do_rd;

   // A full queue refuses writes even when a read happens in the same cycle
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Pointer advance; extra MSB distinguishes full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_reg[LOG_DEPTH-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg[LOG_DEPTH-1:0]];

   generate
      if (USE_SOFT) begin : g_soft
         logic [LOG_DEPTH:0] count_reg;

         // Occupancy counter drives the flags
         always_ff @(posedge clk) begin
            if (rst) begin
               count_reg <= '0;
            end else begin
               case ({do_wr, do_rd})
                  2'b10:   count_reg <= count_reg + 1'b1;
                  2'b01:   count_reg <= count_reg - 1'b1;
                  default: count_reg <= count_reg;
               endcase
            end
         end

         assign full  = (count_reg == (LOG_DEPTH+1)'(DEPTH));
         assign empty = (count_reg == '0);
      end else begin : g_ptr
         assign empty = (wr_ptr_reg == rd_ptr_reg);
         assign full  = (wr_ptr_reg[LOG_DEPTH] != rd_ptr_reg[LOG_DEPTH]) &&
                        (wr_ptr_reg[LOG_DEPTH-1:0] == rd_ptr_reg[LOG_DEPTH-1:0]);
      end
   endgenerate

endmodule

// File: rtl/dnn_ami_write_sequencer.sv
// Splits macro write requests into 8-byte AMI writes fed from PU output buffers.
module dnn_ami_write_sequencer
   import dnn_ami_write_sequencer_pkg::*;
#(
   parameter int NUM_PU            = 2,
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int AXI_DATA_WIDTH    = 64,
   parameter int TX_SIZE_WIDTH     = 10,
   parameter int NUM_PU_W          = $clog2(NUM_PU) + 1,
   parameter int MACRO_Q_LOG_DEPTH = MACRO_Q_LOG_DEPTH_DEF,
   parameter int REQ_Q_LOG_DEPTH   = REQ_Q_LOG_DEPTH_DEF,
   parameter bit USE_SOFT_FIFO     = 1'b0,
   localparam int AMI_REQ_W        = ami_req_width(AXI_DATA_WIDTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             reqValid,
   input  logic                             reqOut_grant,
   output logic [AMI_REQ_W-1:0]             reqOut,
   input  logic [NUM_PU-1:0]                outbuf_empty,
   input  logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_from_outbuf,
   input  logic [NUM_PU-1:0]                write_valid,
   output logic [NUM_PU-1:0]                outbuf_pop,
   input  logic                             wr_req,
   input  logic [NUM_PU_W-1:0]              wr_pu_id,
   input  logic [TX_SIZE_WIDTH-1:0]         wr_req_size,
   input  logic [AXI_ADDR_WIDTH-1:0]        wr_addr,
   output logic                             wr_ready,
   output logic                             wr_done
);
   localparam int AMI_ADDR_LSB = ami_addr_lsb(AXI_DATA_WIDTH);
   localparam int AMI_WR_BIT   = ami_is_write_bit(AXI_DATA_WIDTH);
   localparam int AMI_VAL_BIT  = ami_valid_bit(AXI_DATA_WIDTH);
   localparam int MQ_SIZE_LSB  = mem_size_lsb(NUM_PU_W);
   localparam int MQ_ADDR_LSB  = mem_addr_lsb(NUM_PU_W, TX_SIZE_WIDTH);
   localparam int MQ_WR_BIT    = mem_is_write_bit(NUM_PU_W, TX_SIZE_WIDTH, AXI_ADDR_WIDTH);
   localparam int MQ_VAL_BIT   = mem_valid_bit(NUM_PU_W, TX_SIZE_WIDTH, AXI_ADDR_WIDTH);
   localparam int MQ_W         = mem_req_width(NUM_PU_W, TX_SIZE_WIDTH, AXI_ADDR_WIDTH);

   seq_state_t                  state_reg, state_next;
   logic [AXI_ADDR_WIDTH-1:0]   cur_addr_reg, cur_addr_next;
   logic [TX_SIZE_WIDTH-1:0]    left_reg, left_next;
   logic [NUM_PU_W-1:0]         pu_id_reg, pu_id_next;
   logic                        done_reg, done_next;
   logic [63:0]                 ts_reg;

   logic [MQ_W-1:0]             macro_din, macro_head;
   logic                        macro_full, macro_empty, macro_rd;
   logic [AMI_REQ_W-1:0]        req_din;
   logic                        req_full, req_empty, req_rd;
   logic                        issue;

   logic [NUM_PU-1:0]           pu_hit;
   logic [AXI_DATA_WIDTH-1:0]   pu_slice [NUM_PU];
   logic [AXI_DATA_WIDTH-1:0]   beat_data;
   logic                        beat_avail;
   logic                        unused_ok;

   // Free-running timestamp stamped into each macro entry
   always_ff @(posedge clk) begin
      if (rst) ts_reg <= '0;
      else     ts_reg <= ts_reg + 64'd1;
   end

   // Assemble the macro queue entry from the request ports
   always_comb begin
      macro_din = '0;
      macro_din[MEM_TS_LSB +: MEM_TS_W]         = ts_reg;
      macro_din[MEM_PU_LSB +: NUM_PU_W]         = wr_pu_id;
      macro_din[MQ_SIZE_LSB +: TX_SIZE_WIDTH]   = wr_req_size;
      macro_din[MQ_ADDR_LSB +: AXI_ADDR_WIDTH]  = wr_addr;
      macro_din[MQ_WR_BIT]                      = 1'b1;
      macro_din[MQ_VAL_BIT]                     = 1'b1;
   end

   sync_fifo #(
      .WIDTH     (MQ_W),
      .LOG_DEPTH (MACRO_Q_LOG_DEPTH),
      .USE_SOFT  (USE_SOFT_FIFO)
   ) u_macro_q (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_req),
      .wr_data (macro_din),
      .rd_en   (macro_rd),
      .rd_data (macro_head),
      .full    (macro_full),
      .empty   (macro_empty)
   );

   // Per-PU select decode and data slicing
   generate
      for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_pu
         assign pu_hit[gi]   = (pu_id_reg == NUM_PU_W'(gi));
         assign pu_slice[gi] = data_from_outbuf[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
   endgenerate

   // Mux the selected PU's data beat; out-of-range ids select nothing
   always_comb begin
      beat_data = '0;
      for (int i = 0; i < NUM_PU; i++) begin
         if (pu_hit[i]) beat_data = beat_data | pu_slice[i];
      end
   end

   assign beat_avail = |(pu_hit & ~outbuf_empty);
   assign outbuf_pop = issue ? pu_hit : '0;

   // Sequencer state and beat-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= SEQ_IDLE;
         cur_addr_reg <= '0;
         left_reg     <= '0;
         pu_id_reg    <= '0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cur_addr_reg <= cur_addr_next;
         left_reg     <= left_next;
         pu_id_reg    <= pu_id_next;
         done_reg     <= done_next;
      end
   end

   // Next-state: load a macro entry in IDLE, issue one beat per cycle in ACTIVE
   always_comb begin
      state_next    = state_reg;
      cur_addr_next = cur_addr_reg;
      left_next     = left_reg;
      pu_id_next    = pu_id_reg;
      done_next     = 1'b0;
      macro_rd      = 1'b0;
      issue         = 1'b0;
      case (state_reg)
         SEQ_IDLE: begin
            if (!macro_empty) begin
               macro_rd      = 1'b1;
               cur_addr_next = macro_head[MQ_ADDR_LSB +: AXI_ADDR_WIDTH];
               left_next     = macro_head[MQ_SIZE_LSB +: TX_SIZE_WIDTH];
               pu_id_next    = macro_head[MEM_PU_LSB +: NUM_PU_W];
               state_next    = SEQ_ACTIVE;
            end
         end
         SEQ_ACTIVE: begin
            if (left_reg == '0) begin
               // Zero-length request completes without touching the buffer
               state_next = SEQ_IDLE;
               done_next  = 1'b1;
            end else if (beat_avail && !req_full) begin
               issue         = 1'b1;
               cur_addr_next = cur_addr_reg + AXI_ADDR_WIDTH'(8);
               left_next     = left_reg - TX_SIZE_WIDTH'(1);
               if (left_reg == TX_SIZE_WIDTH'(1)) begin
                  state_next = SEQ_IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = SEQ_IDLE;
      endcase
   end

   // Assemble the outbound AMI write request for the current beat
   always_comb begin
      req_din = '0;
      req_din[AMI_SIZE_LSB +: AMI_SIZE_W]     = AMI_BEAT_BYTES;
      req_din[AMI_DATA_LSB +: AXI_DATA_WIDTH] = beat_data;
      req_din[AMI_ADDR_LSB +: AMI_ADDR_W]     = AMI_ADDR_W'(cur_addr_reg);
      req_din[AMI_WR_BIT]                     = 1'b1;
      req_din[AMI_VAL_BIT]                    = 1'b1;
   end

   sync_fifo #(
      .WIDTH     (AMI_REQ_W),
      .LOG_DEPTH (REQ_Q_LOG_DEPTH),
      .USE_SOFT  (USE_SOFT_FIFO)
   ) u_req_q (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (issue),
      .wr_data (req_din),
      .rd_en   (req_rd),
      .rd_data (reqOut),
      .full    (req_full),
      .empty   (req_empty)
   );

   assign reqValid = !req_empty && reqOut[AMI_VAL_BIT];
   assign req_rd   = reqOut_grant && reqValid;
   assign wr_done  = done_reg;
   assign wr_ready = macro_empty && (state_reg == SEQ_IDLE) && req_empty;

   // Fields carried for downstream visibility only; macro_full is reported via wr_ready
   assign unused_ok = ^{write_valid, macro_full, macro_head[MEM_TS_LSB +: MEM_TS_W],
                        macro_head[MQ_WR_BIT], macro_head[MQ_VAL_BIT]};

endmodule

// File: tb/tb_dnn_ami_write_sequencer.sv
// Scoreboard bench for dnn_ami_write_sequencer.
module tb_dnn_ami_write_sequencer;
   localparam int NUM_PU    = 2;
   localparam int AW        = 32;
   localparam int DW        = 64;
   localparam int SW        = 10;
   localparam int PW        = 2;
   localparam int REQ_W     = 138;
   localparam int REQ_DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 reqValid;
   logic                 reqOut_grant;
   logic [REQ_W-1:0]     reqOut;
   logic [NUM_PU-1:0]    outbuf_empty;
   logic [NUM_PU*DW-1:0] data_from_outbuf;
   logic [NUM_PU-1:0]    write_valid;
   logic [NUM_PU-1:0]    outbuf_pop;
   logic                 wr_req;
   logic [PW-1:0]        wr_pu_id;
   logic [SW-1:0]        wr_req_size;
   logic [AW-1:0]        wr_addr;
   logic                 wr_ready;
   logic                 wr_done;

   always #5 clk = ~clk;

   dnn_ami_write_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .reqValid         (reqValid),
      .reqOut_grant     (reqOut_grant),
      .reqOut           (reqOut),
      .outbuf_empty     (outbuf_empty),
      .data_from_outbuf (data_from_outbuf),
      .write_valid      (write_valid),
      .outbuf_pop       (outbuf_pop),
      .wr_req           (wr_req),
      .wr_pu_id         (wr_pu_id),
      .wr_req_size      (wr_req_size),
      .wr_addr          (wr_addr),
      .wr_ready         (wr_ready),
      .wr_done          (wr_done)
   );

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    pop_pu_q[$];
   int    pop_cnt [NUM_PU] = '{default: 0};
   int    exp_n   [NUM_PU] = '{default: 0};
   int    n_checks = 0;
   int    n_fail   = 0;
   int    acc_cnt  = 0;
   int    pop_seen = 0;
   int    done_cnt = 0;
   int    valid_cnt = 0;
   int    empty_mode = 2;
   logic  tog = 1'b0;

   // Each PU buffer yields a tagged, incrementing data word per pop
   function automatic logic [63:0] pu_data(input int p, input int n);
      return {24'hA0A0A0, 8'(p), 32'(n)};
   endfunction

   always_comb begin
      for (int p = 0; p < NUM_PU; p++) begin
         data_from_outbuf[p*DW +: DW] = pu_data(p, pop_cnt[p]);
         case (empty_mode)
            0:       outbuf_empty[p] = 1'b0;
            1:       outbuf_empty[p] = tog;
            default: outbuf_empty[p] = 1'b1;
         endcase
      end
   end

   always @(posedge clk) begin
      tog <= ~tog;
      for (int p = 0; p < NUM_PU; p++) begin
         if (outbuf_pop[p] && !outbuf_empty[p]) pop_cnt[p] <= pop_cnt[p] + 1;
      end
   end

   // Monitor: compare accepted requests and pops against the scoreboard
   beat_t            mb;
   logic [REQ_W-1:0] exp_word;
   int               mp;
   logic [NUM_PU-1:0] exp_pop;
   always @(negedge clk) begin
      if (!rst) begin
         if (reqValid) valid_cnt++;
         if (reqValid && reqOut_grant) begin
            acc_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL req_unexpected: got reqOut %h, none expected", reqOut);
            end else begin
               mb = exp_q.pop_front();
               exp_word = {1'b1, 1'b1, mb.addr, mb.data, 8'd8};
               if (reqOut !== exp_word) begin
                  n_fail++;
                  $display("FAIL req_content: got %h, expected %h", reqOut, exp_word);
               end
               $display("req addr=%h data=%h", mb.addr, mb.data);
            end
         end
         if (|outbuf_pop) begin
            pop_seen++;
            n_checks++;
            if (pop_pu_q.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got outbuf_pop %b, none expected", outbuf_pop);
            end else begin
               mp = pop_pu_q.pop_front();
               exp_pop = NUM_PU'(1) << mp;
               if (outbuf_pop !== exp_pop || (outbuf_pop & outbuf_empty) != '0) begin
                  n_fail++;
                  $display("FAIL pop_select: got pop %b (empty %b), expected %b on non-empty",
                           outbuf_pop, outbuf_empty, exp_pop);
               end
            end
         end
         if (wr_done) done_cnt++;
      end
   end

   task automatic send(input logic [31:0] a, input int sz, input int p);
      @(posedge clk); #1;
      wr_req      = 1'b1;
      wr_addr     = a;
      wr_req_size = SW'(sz);
      wr_pu_id    = PW'(p);
      for (int k = 0; k < sz; k++) begin
         exp_q.push_back('{addr: 64'(a + 32'(8 * k)), data: pu_data(p, exp_n[p])});
         pop_pu_q.push_back(p);
         exp_n[p]++;
      end
   endtask

   task automatic release_req();
      @(posedge clk); #1;
      wr_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int cyc = 0;
      @(posedge clk);
      do begin
         @(negedge clk);
         cyc++;
      end while (!(wr_ready && exp_q.size() == 0) && cyc < budget);
      n_checks++;
      if (!(wr_ready && exp_q.size() == 0)) begin
         n_fail++;
         $display("FAIL %s_timeout: wr_ready=%b pending=%0d after %0d cycles, expected idle",
                  name, wr_ready, exp_q.size(), cyc);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks += 4;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
      if (reqValid !== 1'b0) begin n_fail++; $display("FAIL reset_reqValid: got %b, expected 0", reqValid); end
      if (wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done: got %b, expected 0", wr_done); end
      if (outbuf_pop !== 2'b00) begin n_fail++; $display("FAIL reset_pop: got %b, expected 00", outbuf_pop); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int a0 = acc_cnt, p0 = pop_seen, d0 = done_cnt;
      reqOut_grant = 1'b1;
      empty_mode   = 0;
      send(32'h1000, 3, 1);
      release_req();
      wait_idle(60, "basic");
      check_int("basic_accepted", acc_cnt - a0, 3);
      check_int("basic_pops", pop_seen - p0, 3);
      check_int("basic_done", done_cnt - d0, 1);
      n_checks++;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL basic_wr_ready: got %b, expected 1", wr_ready); end
   endtask

   task automatic test_toggle();
      int a0 = acc_cnt, p0 = pop_seen, d0 = done_cnt;
      empty_mode = 1;
      send(32'h1000, 3, 1);
      release_req();
      wait_idle(60, "toggle");
      check_int("toggle_accepted", acc_cnt - a0, 3);
      check_int("toggle_pops", pop_seen - p0, 3);
      check_int("toggle_done", done_cnt - d0, 1);
      empty_mode = 0;
   endtask

   task automatic test_backpressure();
      int a0 = acc_cnt, p0 = pop_seen, d0 = done_cnt;
      reqOut_grant = 1'b0;
      send(32'h2000, REQ_DEPTH + 2, 0);
      release_req();
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_int("bp_pops_at_full", pop_seen - p0, REQ_DEPTH);
      check_int("bp_done_stalled", done_cnt - d0, 0);
      n_checks += 2;
      if (reqValid !== 1'b1) begin n_fail++; $display("FAIL bp_reqValid: got %b, expected 1", reqValid); end
      if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_wr_ready: got %b, expected 0", wr_ready); end
      @(posedge clk); #1 reqOut_grant = 1'b1;
      wait_idle(80, "bp");
      check_int("bp_accepted", acc_cnt - a0, REQ_DEPTH + 2);
      check_int("bp_pops_total", pop_seen - p0, REQ_DEPTH + 2);
      check_int("bp_done", done_cnt - d0, 1);
   endtask

   task automatic test_size0();
      int p0 = pop_seen, d0 = done_cnt, v0 = valid_cnt;
      send(32'h3000, 0, 0);
      release_req();
      wait_idle(40, "size0");
      check_int("size0_pops", pop_seen - p0, 0);
      check_int("size0_valid", valid_cnt - v0, 0);
      check_int("size0_done", done_cnt - d0, 1);
   endtask

   task automatic test_back_to_back();
      int a0 = acc_cnt, d0 = done_cnt;
      send(32'h0, 2, 0);
      send(32'h100, 1, 1);
      release_req();
      wait_idle(60, "b2b");
      check_int("b2b_accepted", acc_cnt - a0, 3);
      check_int("b2b_done", done_cnt - d0, 2);
   endtask

   task automatic test_reset_mid();
      int a0;
      reqOut_grant = 1'b0;
      send(32'h4000, 6, 1);
      release_req();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks += 4;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_ready: got %b, expected 1", wr_ready); end
      if (reqValid !== 1'b0) begin n_fail++; $display("FAIL midrst_reqValid: got %b, expected 0", reqValid); end
      if (wr_done !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_done: got %b, expected 0", wr_done); end
      if (outbuf_pop !== 2'b00) begin n_fail++; $display("FAIL midrst_pop: got %b, expected 00", outbuf_pop); end
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      pop_pu_q.delete();
      for (int p = 0; p < NUM_PU; p++) exp_n[p] = pop_cnt[p];
      reqOut_grant = 1'b1;
      a0 = acc_cnt;
      send(32'h5000, 2, 1);
      release_req();
      wait_idle(60, "postrst");
      check_int("postrst_accepted", acc_cnt - a0, 2);
   endtask

   initial begin
      rst          = 1'b1;
      reqOut_grant = 1'b0;
      write_valid  = '0;
      wr_req       = 1'b0;
      wr_pu_id     = '0;
      wr_req_size  = '0;
      wr_addr      = '0;
      test_reset();
      test_basic();
      test_toggle();
      test_backpressure();
      test_size0();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
